// File: rtl/ray_issue_scheduler_if.sv
// Request/completion link between ray_issue_scheduler (master) and ray_unit (slave).
interface ray_issue_scheduler_if;
   logic signed [31:0] screen_x;
   logic signed [31:0] screen_y;
   logic               valid_out;
   logic               ray_done;

   modport master (
      output screen_x,
      output screen_y,
      output valid_out,
      input  ray_done
   );

   modport slave (
      input  screen_x,
      input  screen_y,
      input  valid_out,
      output ray_done
   );
endinterface

// File: rtl/ray_issue_scheduler.sv
// Raster-order, credit-limited pixel issuer feeding ray_unit with Q16.16 screen coordinates.
// Define RAY_ISSUE_CONTINUOUS_EN to restart the next frame automatically after each frame.
module ray_issue_scheduler #(
   parameter int H_RES        = 640,
   parameter int V_RES        = 480,
   parameter int STEP         = 273,
   parameter int MAX_INFLIGHT = 64
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_start,
   input  logic                               i_abort,
   ray_issue_scheduler_if.master              ray_if,
   output logic [$clog2(H_RES)-1:0]           o_pix_x,
   output logic [$clog2(V_RES)-1:0]           o_pix_y,
   output logic                               o_busy,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0]  o_inflight,
   output logic                               o_frame_done,
   output logic                               o_overflow_err
);

   localparam int XW = $clog2(H_RES);
   localparam int YW = $clog2(V_RES);
   localparam int IW = $clog2(MAX_INFLIGHT + 1);

   localparam int HALF_X = ((H_RES - 1) * STEP) >>> 1;
   localparam int HALF_Y = ((V_RES - 1) * STEP) >>> 1;
   localparam logic signed [31:0] X_START = 32'(-HALF_X);
   localparam logic signed [31:0] Y_START = 32'(HALF_Y);
   localparam logic signed [31:0] STEP32  = 32'(STEP);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_t;

   state_t             r_state;
   logic [XW-1:0]      r_col;
   logic [YW-1:0]      r_row;
   logic signed [31:0] r_x_acc;
   logic signed [31:0] r_y_acc;
   logic               r_aborted;
   logic signed [31:0] r_screen_x;
   logic signed [31:0] r_screen_y;
   logic               r_valid;
   logic [XW-1:0]      r_pix_x;
   logic [YW-1:0]      r_pix_y;
   logic               r_busy;
   logic [IW-1:0]      r_inflight;
   logic               r_frame_done;
   logic               r_overflow;

   logic w_full;
   logic w_issue;
   logic w_done_eff;
   logic w_eol;
   logic w_last;

   assign w_full     = (r_inflight == IW'(MAX_INFLIGHT));
   assign w_issue    = (r_state == StIssue) && !w_full && !i_abort;
   // A completion with nothing outstanding is a protocol error, never an underflow.
   assign w_done_eff = ray_if.ray_done && (r_inflight != '0);
   assign w_eol      = (r_col == XW'(H_RES - 1));
   assign w_last     = w_eol && (r_row == YW'(V_RES - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_col        <= '0;
         r_row        <= '0;
         r_x_acc      <= '0;
         r_y_acc      <= '0;
         r_aborted    <= 1'b0;
         r_screen_x   <= '0;
         r_screen_y   <= '0;
         r_valid      <= 1'b0;
         r_pix_x      <= '0;
         r_pix_y      <= '0;
         r_busy       <= 1'b0;
         r_inflight   <= '0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_valid      <= 1'b0;
         r_frame_done <= 1'b0;

         if (ray_if.ray_done && (r_inflight == '0)) r_overflow <= 1'b1;

         if (w_issue && !w_done_eff)      r_inflight <= r_inflight + IW'(1);
         else if (!w_issue && w_done_eff) r_inflight <= r_inflight - IW'(1);

         case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_col   <= '0;
                  r_row   <= '0;
                  r_x_acc <= X_START;
                  r_y_acc <= Y_START;
                  r_state <= StIssue;
                  r_busy  <= 1'b1;
               end
            end
            StIssue: begin
               if (i_abort) begin
                  r_state   <= StDrain;
                  r_aborted <= 1'b1;
               end else if (w_issue) begin
                  r_valid    <= 1'b1;
                  r_screen_x <= r_x_acc;
                  r_screen_y <= r_y_acc;
                  r_pix_x    <= r_col;
                  r_pix_y    <= r_row;
                  if (w_last) begin
                     r_state <= StDrain;
                  end else if (w_eol) begin
                     r_col   <= '0;
                     r_x_acc <= X_START;
                     r_row   <= r_row + YW'(1);
                     r_y_acc <= r_y_acc - STEP32;
                  end else begin
                     r_col   <= r_col + XW'(1);
                     r_x_acc <= r_x_acc + STEP32;
                  end
               end
            end
            StDrain: begin
               if (r_inflight == '0) begin
                  r_frame_done <= !r_aborted;
                  r_aborted    <= 1'b0;
`ifdef RAY_ISSUE_CONTINUOUS_EN
                  if (!r_aborted) begin
                     r_col   <= '0;
                     r_row   <= '0;
                     r_x_acc <= X_START;
                     r_y_acc <= Y_START;
                     r_state <= StIssue;
                  end else begin
                     r_state <= StIdle;
                     r_busy  <= 1'b0;
                  end
`else
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
`endif
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign ray_if.screen_x  = r_screen_x;
   assign ray_if.screen_y  = r_screen_y;
   assign ray_if.valid_out = r_valid;
   assign o_pix_x          = r_pix_x;
   assign o_pix_y          = r_pix_y;
   assign o_busy           = r_busy;
   assign o_inflight       = r_inflight;
   assign o_frame_done     = r_frame_done;
   assign o_overflow_err   = r_overflow;

endmodule

// File: tb/tb_ray_issue_scheduler.sv
// Bench for ray_issue_scheduler: 4x3 frame, STEP=16384; DUT a (16 credits), DUT b (2 credits).
module tb_ray_issue_scheduler;

   logic clk;
   logic rst;
   logic start_a, abort_a, man_done_a, auto_a;
   logic start_b, abort_b, man_done_b;
   logic [3:0] pipe_a;

   logic [1:0] pix_x_a, pix_y_a, pix_x_b, pix_y_b;
   logic       busy_a, busy_b, fd_a, fd_b, ovf_a, ovf_b;
   logic [4:0] inflight_a;
   logic [1:0] inflight_b;

   int n_checks;
   int n_fail;
   int vcnt_a, fdcnt_a, vcnt_b;

   typedef struct {
      int col;
      int row;
      int x;
      int y;
   } pix_t;
   pix_t sb_q[$];
   pix_t exp_p;

   ray_issue_scheduler_if if_a ();
   ray_issue_scheduler_if if_b ();

   ray_issue_scheduler #(
      .H_RES(4), .V_RES(3), .STEP(16384), .MAX_INFLIGHT(16)
   ) dut_a (
      .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_abort(abort_a), .ray_if(if_a),
      .o_pix_x(pix_x_a), .o_pix_y(pix_y_a), .o_busy(busy_a), .o_inflight(inflight_a),
      .o_frame_done(fd_a), .o_overflow_err(ovf_a)
   );

   ray_issue_scheduler #(
      .H_RES(4), .V_RES(3), .STEP(16384), .MAX_INFLIGHT(2)
   ) dut_b (
      .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_abort(abort_b), .ray_if(if_b),
      .o_pix_x(pix_x_b), .o_pix_y(pix_y_b), .o_busy(busy_b), .o_inflight(inflight_b),
      .o_frame_done(fd_b), .o_overflow_err(ovf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Ray unit model for dut_a: completion 4 cycles after each issue when auto_a is set.
   assign if_a.ray_done = (auto_a & pipe_a[3]) | man_done_a;
   assign if_b.ray_done = man_done_b;

   always @(negedge clk) begin
      pipe_a = rst ? 4'b0 : {pipe_a[2:0], if_a.valid_out};
   end

   // Scoreboard consumer for dut_a plus event counters.
   always @(negedge clk) begin
      if (!rst && fd_a) fdcnt_a++;
      if (!rst && if_b.valid_out) vcnt_b++;
      if (!rst && if_a.valid_out) begin
         vcnt_a++;
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected got pix=(%0d,%0d) x=%0d y=%0d required no issue",
                     pix_x_a, pix_y_a, if_a.screen_x, if_a.screen_y);
         end else begin
            exp_p = sb_q.pop_front();
            if (32'(pix_x_a) !== exp_p.col || 32'(pix_y_a) !== exp_p.row ||
                if_a.screen_x !== exp_p.x || if_a.screen_y !== exp_p.y) begin
               n_fail++;
               $display("FAIL sb_pixel got (%0d,%0d) x=%0d y=%0d required (%0d,%0d) x=%0d y=%0d",
                        pix_x_a, pix_y_a, if_a.screen_x, if_a.screen_y,
                        exp_p.col, exp_p.row, exp_p.x, exp_p.y);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_pixels(input int n);
      pix_t p;
      for (int i = 0; i < n; i++) begin
         p.col = i % 4;
         p.row = (i / 4) % 3;
         p.x   = -24576 + p.col * 16384;
         p.y   = 16384 - p.row * 16384;
         sb_q.push_back(p);
      end
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      n_checks++;
      if ({if_a.valid_out, busy_a, fd_a, ovf_a, inflight_a, pix_x_a, pix_y_a} !== '0 ||
          if_a.screen_x !== 32'sd0 || if_a.screen_y !== 32'sd0) begin
         n_fail++;
         $display("FAIL reset_outputs got v=%b busy=%b inflight=%0d x=%0d y=%0d required all 0",
                  if_a.valid_out, busy_a, inflight_a, if_a.screen_x, if_a.screen_y);
      end
      rst = 1'b0;
      tick();
      tick();
      n_checks++;
      if (busy_a !== 1'b0 || if_a.valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle got busy=%b valid=%b required 0 0", busy_a, if_a.valid_out);
      end
   endtask

`ifndef RAY_ISSUE_CONTINUOUS_EN
   task automatic wait_frame_done_a(input int fd0);
      for (int i = 0; i < 100 && fdcnt_a == fd0; i++) tick();
      tick();
   endtask

   task automatic test_frame();
      int v0, fd0;
      v0 = vcnt_a;
      fd0 = fdcnt_a;
      auto_a = 1'b1;
      push_pixels(12);
      pulse_start_a();
      n_checks++;
      if (if_a.valid_out !== 1'b0 || busy_a !== 1'b1) begin
         n_fail++;
         $display("FAIL start_latency got valid=%b busy=%b required 0 1", if_a.valid_out, busy_a);
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         n_checks++;
         if (if_a.valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back beat %0d got valid=%b required 1", i, if_a.valid_out);
         end
      end
      wait_frame_done_a(fd0);
      tick();
      n_checks++;
      if (fdcnt_a != fd0 + 1 || busy_a !== 1'b0 || inflight_a !== 5'd0 ||
          vcnt_a != v0 + 12 || sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL frame_end got fd=%0d busy=%b inflight=%0d issues=%0d left=%0d required 1 0 0 12 0",
                  fdcnt_a - fd0, busy_a, inflight_a, vcnt_a - v0, sb_q.size());
      end
   endtask

   task automatic test_abort();
      int v0, fd0;
      v0 = vcnt_a;
      fd0 = fdcnt_a;
      push_pixels(5);
      pulse_start_a();
      for (int i = 0; i < 30 && vcnt_a < v0 + 5; i++) tick();
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      for (int i = 0; i < 50 && busy_a !== 1'b0; i++) tick();
      tick();
      n_checks++;
      if (fdcnt_a != fd0 || vcnt_a != v0 + 5 || inflight_a !== 5'd0 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_drain got fd=%0d issues=%0d inflight=%0d busy=%b required 0 5 0 0",
                  fdcnt_a - fd0, vcnt_a - v0, inflight_a, busy_a);
      end
      v0 = vcnt_a;
      push_pixels(12);
      pulse_start_a();
      wait_frame_done_a(fd0);
      tick();
      n_checks++;
      if (fdcnt_a != fd0 + 1 || vcnt_a != v0 + 12 || sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL abort_restart got fd=%0d issues=%0d left=%0d required 1 12 0",
                  fdcnt_a - fd0, vcnt_a - v0, sb_q.size());
      end
   endtask

   task automatic test_overflow();
      int v0, fd0;
      man_done_a = 1'b1;
      tick();
      man_done_a = 1'b0;
      tick();
      n_checks++;
      if (inflight_a !== 5'd0 || ovf_a !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow got inflight=%0d ovf=%b required 0 1", inflight_a, ovf_a);
      end
      v0 = vcnt_a;
      fd0 = fdcnt_a;
      push_pixels(12);
      pulse_start_a();
      for (int i = 0; i < 30 && vcnt_a < v0 + 5; i++) tick();
      pulse_start_a();
      wait_frame_done_a(fd0);
      tick();
      n_checks++;
      if (fdcnt_a != fd0 + 1 || vcnt_a != v0 + 12 || sb_q.size() != 0 || ovf_a !== 1'b1) begin
         n_fail++;
         $display("FAIL start_ignored got fd=%0d issues=%0d left=%0d ovf=%b required 1 12 0 1",
                  fdcnt_a - fd0, vcnt_a - v0, sb_q.size(), ovf_a);
      end
   endtask

   task automatic test_credit_stall();
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      n_checks++;
      if (vcnt_b != 2 || inflight_b !== 2'd2 || busy_b !== 1'b1) begin
         n_fail++;
         $display("FAIL credit_stall got issues=%0d inflight=%0d busy=%b required 2 2 1",
                  vcnt_b, inflight_b, busy_b);
      end
      man_done_b = 1'b1;
      tick();
      man_done_b = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_checks++;
      if (vcnt_b != 3 || pix_x_b !== 2'd2 || pix_y_b !== 2'd0 || inflight_b !== 2'd2) begin
         n_fail++;
         $display("FAIL credit_release got issues=%0d pix=(%0d,%0d) inflight=%0d required 3 (2,0) 2",
                  vcnt_b, pix_x_b, pix_y_b, inflight_b);
      end
   endtask

   task automatic test_same_cycle();
      man_done_b = 1'b1;
      tick();
      n_checks++;
      if (inflight_b !== 2'd1 || if_b.valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL full_done got inflight=%0d valid=%b required 1 0", inflight_b, if_b.valid_out);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (inflight_b !== 2'd1 || if_b.valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle beat %0d got inflight=%0d valid=%b required 1 1",
                     i, inflight_b, if_b.valid_out);
         end
      end
      man_done_b = 1'b0;
      n_checks++;
      if (vcnt_b != 7 || pix_x_b !== 2'd2 || pix_y_b !== 2'd1) begin
         n_fail++;
         $display("FAIL same_cycle_pix got issues=%0d pix=(%0d,%0d) required 7 (2,1)",
                  vcnt_b, pix_x_b, pix_y_b);
      end
   endtask

   task automatic test_reset_mid();
      int v0;
      auto_a = 1'b0;
      v0 = vcnt_a;
      push_pixels(3);
      pulse_start_a();
      for (int i = 0; i < 20 && vcnt_a < v0 + 3; i++) tick();
      n_checks++;
      if (inflight_a !== 5'd3) begin
         n_fail++;
         $display("FAIL pre_reset_inflight got %0d required 3", inflight_a);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({if_a.valid_out, busy_a, fd_a, ovf_a, inflight_a, pix_x_a, pix_y_a} !== '0 ||
          if_a.screen_x !== 32'sd0 || if_a.screen_y !== 32'sd0) begin
         n_fail++;
         $display("FAIL async_reset got v=%b busy=%b ovf=%b inflight=%0d x=%0d required all 0",
                  if_a.valid_out, busy_a, ovf_a, inflight_a, if_a.screen_x);
      end
      tick();
      rst = 1'b0;
      v0 = vcnt_a;
      for (int i = 0; i < 6; i++) tick();
      n_checks++;
      if (vcnt_a != v0 || busy_a !== 1'b0 || inflight_a !== 5'd0 || sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL post_reset_idle got issues=%0d busy=%b inflight=%0d left=%0d required 0 0 0 0",
                  vcnt_a - v0, busy_a, inflight_a, sb_q.size());
      end
   endtask
`else
   task automatic test_continuous();
      int fd0;
      fd0 = fdcnt_a;
      auto_a = 1'b1;
      push_pixels(36);
      pulse_start_a();
      for (int i = 0; i < 200 && fdcnt_a < fd0 + 2; i++) begin
         tick();
         n_checks++;
         if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL continuous_busy cycle %0d got %b required 1", i, busy_a);
         end
      end
      n_checks++;
      if (fdcnt_a != fd0 + 2) begin
         n_fail++;
         $display("FAIL continuous_frames got %0d required 2", fdcnt_a - fd0);
      end
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      for (int i = 0; i < 50 && busy_a !== 1'b0; i++) tick();
      sb_q.delete();
      n_checks++;
      if (busy_a !== 1'b0 || fdcnt_a != fd0 + 2) begin
         n_fail++;
         $display("FAIL continuous_abort got busy=%b fd=%0d required 0 2", busy_a, fdcnt_a - fd0);
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail = 0;
      vcnt_a = 0;
      vcnt_b = 0;
      fdcnt_a = 0;
      pipe_a = '0;
      rst = 1'b1;
      start_a = 1'b0;
      abort_a = 1'b0;
      man_done_a = 1'b0;
      auto_a = 1'b0;
      start_b = 1'b0;
      abort_b = 1'b0;
      man_done_b = 1'b0;
      test_reset();
`ifndef RAY_ISSUE_CONTINUOUS_EN
      test_frame();
      test_abort();
      test_overflow();
      test_credit_stall();
      test_same_cycle();
      test_reset_mid();
`else
      test_continuous();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ray_issue_scheduler.md
Name: ray_issue_scheduler

Overview:
Frame-level pixel scanner that drives the ray unit's screen_x/screen_y/valid_in request port. On start it walks an H_RES x V_RES frame in raster order and emits one signed Q16.16 screen coordinate pair per issued pixel. Issue is credit-limited against the ray unit's valid_out completions, because the ray unit has no ready signal. It sits between the frame controller/CSRs and ray_unit.

Parameters:
H_RES, 640, pixels per line (>=2)
V_RES, 480, lines per frame (>=2)
STEP, 273, signed Q16.16 screen-space step per pixel; square pixels (~2/480)
MAX_INFLIGHT, 64, maximum rays issued and not yet completed (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle frame start request; honoured only in IDLE
abort  in  1  stop issuing; drain in-flight rays, then return to IDLE
ray_done  in  1  one completion from ray_unit valid_out
screen_x  out  32  signed Q16.16, to ray_unit screen_x
screen_y  out  32  signed Q16.16, to ray_unit screen_y
valid_out  out  1  issue strobe, to ray_unit valid_in
pix_x  out  $clog2(H_RES)  integer column of the issued pixel
pix_y  out  $clog2(V_RES)  integer row of the issued pixel
busy  out  1  high in any state other than IDLE
inflight  out  $clog2(MAX_INFLIGHT+1)  outstanding ray count
frame_done  out  1  single-cycle pulse on completion of a full frame
overflow_err  out  1  sticky; set when ray_done arrives with inflight==0

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted, all outputs are 0 and the state is IDLE; inflight=0.
- Derived constants: X_START = -(((H_RES-1)*STEP)>>>1) and Y_START = +(((V_RES-1)*STEP)>>>1). x increases left to right; y decreases top to bottom.
- Coordinates are generated incrementally, with no multipliers:
  - screen_x += STEP on each issue.
  - At end of line, screen_x reloads X_START and screen_y -= STEP.
  - Accumulators are 32-bit signed; the defaults cannot overflow.
- All outputs are registered.
- FSM states are IDLE, ISSUE and DRAIN.
  - IDLE: start=1 loads col=0, row=0, x_acc=X_START, y_acc=Y_START, then goes to ISSUE. start in any other state is ignored.
  - ISSUE: a pixel issues on a cycle where inflight != MAX_INFLIGHT and abort=0. On the next edge valid_out=1, with screen_x/screen_y/pix_x/pix_y holding that pixel. Otherwise valid_out=0 and the outputs hold their last values.
  - ISSUE, last pixel: issuing pixel (H_RES-1, V_RES-1) moves the FSM to DRAIN.
  - ISSUE, abort: abort=1 moves the FSM to DRAIN and sets the internal aborted flag. No issue occurs that cycle.
  - DRAIN: when inflight==0, the FSM moves to IDLE. frame_done pulses for one cycle on that transition unless aborted; the aborted flag then clears.
- Latency and throughput:
  - start sampled at edge N gives the first valid_out high after edge N+1.
  - With credits available, issue is 1 pixel/clock, back-to-back, across line boundaries with no bubble.
- Credit accounting:
  - inflight increments on issue and decrements on ray_done.
  - Issue and ray_done in the same cycle leave inflight unchanged.
  - Issue stalls while inflight==MAX_INFLIGHT; a ray_done in that cycle frees a credit for the next cycle.
  - ray_done with inflight==0 is ignored (no underflow) and sets overflow_err. overflow_err clears only on reset.
- ray_done is counted in every state, including IDLE.
- abort in IDLE or DRAIN has no effect.

Optional Feature:
Macro: RAY_ISSUE_CONTINUOUS_EN.
- Defined: DRAIN completing a non-aborted frame pulses frame_done and re-enters ISSUE directly with counters and accumulators reloaded, without waiting for start. abort ends the sequence as normal. busy stays high between frames.
- Undefined: DRAIN always returns to IDLE, and every frame requires start.

Test Plan:
- H_RES=4, V_RES=3, STEP=16384, MAX_INFLIGHT=16, ray_done pulsed 4 cycles after each issue, start pulse: 12 consecutive valid_out.
  - Pixel (0,0): x=-24576, y=16384. Pixel (3,0): x=24576, y=16384. Pixel (0,1): x=-24576, y=0. Pixel (3,2): x=24576, y=-16384.
  - Then a single frame_done pulse and busy=0.
- Same config, MAX_INFLIGHT=2, ray_done held low: exactly 2 valid_out, then stall with inflight=2 and busy=1. One ray_done pulse gives exactly one more issue, pixel (2,0).
- Issue and ray_done in the same cycle at inflight=1: inflight stays 1 and issue continues without stalling.
- abort asserted after 5 issues, completions returned: no further valid_out, DRAIN until inflight=0, IDLE with no frame_done. A following start restarts at pixel (0,0).
- ray_done pulsed in IDLE with inflight=0: inflight stays 0 and overflow_err=1. A start pulse mid-frame is ignored (pixel sequence unchanged).
- Reset asserted mid-frame with inflight=3: all outputs 0 immediately (asynchronously). After release, state is IDLE and nothing issues until start.
- RAY_ISSUE_CONTINUOUS_EN defined: two frames back-to-back from one start, with frame_done pulsing twice and busy never dropping between frames.
